// File: rtl/jft_spi_arb.sv
// Round-robin two-requester arbiter that sequences single-frame transactions into jft_spi.
// Optional completion timeout: define SPI_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module jft_spi_arb #(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        spi_clk_in,
  input  logic        spi_rst_n_in,
  input  logic        req0_valid,
  input  logic        req0_wr,
  input  logic [6:0]  req0_len,
  input  logic [39:0] req0_data,
  output logic        req0_ack,
  output logic        req0_done,
  output logic [31:0] req0_rdata,
  output logic        req0_err,
  input  logic        req1_valid,
  input  logic        req1_wr,
  input  logic [6:0]  req1_len,
  input  logic [39:0] req1_data,
  output logic        req1_ack,
  output logic        req1_done,
  output logic [31:0] req1_rdata,
  output logic        req1_err,
  output logic        spi_start,
  output logic        spi_wr,
  output logic [6:0]  spi_start_number,
  output logic [6:0]  spi_cs_length,
  output logic [39:0] spi_data_in,
  input  logic        spi_end,
  input  logic        spi_data_valid,
  input  logic [31:0] spi_data_out,
  output logic        arb_busy
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BUSY, S_WAIT_RD, S_DONE, S_GAP} state_t;

  localparam logic [3:0] GAP_LAST = 4'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  state_t      state, state_nxt;
  logic        gnt, last_grant, err_q;
  logic [3:0]  gap_cnt;
  logic        any_req, sel, sel_len_ok, abort, tmo_hit;
  logic [6:0]  sel_len;

  assign spi_start_number = 7'd1;

  // On a tie the requester that did not win last time gets the engine.
  always_comb begin
    any_req    = req0_valid | req1_valid;
    sel        = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    sel_len    = sel ? req1_len : req0_len;
    sel_len_ok = (sel_len != 7'd0) && (sel_len <= 7'd40);
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt;
  assign tmo_hit = (tmo_cnt == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge spi_clk_in or negedge spi_rst_n_in) begin
    if (!spi_rst_n_in) state <= S_IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    abort     = 1'b0;
    case (state)
      S_IDLE:    if (any_req) state_nxt = sel_len_ok ? S_START : S_DONE;
      S_START:   state_nxt = S_BUSY;
      S_BUSY: begin
        if (spi_end) begin
          state_nxt = spi_wr ? S_WAIT_RD : S_DONE;
        end else if (tmo_hit) begin
          state_nxt = S_DONE;
          abort     = 1'b1;
        end
      end
      S_WAIT_RD: begin
        if (spi_data_valid) begin
          state_nxt = S_DONE;
        end else if (tmo_hit) begin
          state_nxt = S_DONE;
          abort     = 1'b1;
        end
      end
      S_DONE:    state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      S_GAP:     if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge spi_clk_in or negedge spi_rst_n_in) begin
    if (!spi_rst_n_in) begin
      req0_ack      <= 1'b0;
      req1_ack      <= 1'b0;
      req0_done     <= 1'b0;
      req1_done     <= 1'b0;
      req0_err      <= 1'b0;
      req1_err      <= 1'b0;
      req0_rdata    <= '0;
      req1_rdata    <= '0;
      spi_start     <= 1'b0;
      spi_wr        <= 1'b0;
      spi_cs_length <= '0;
      spi_data_in   <= '0;
      arb_busy      <= 1'b0;
      gnt           <= 1'b0;
      last_grant    <= 1'b1;
      err_q         <= 1'b0;
      gap_cnt       <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      req0_ack  <= 1'b0;
      req1_ack  <= 1'b0;
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      spi_start <= 1'b0;
      arb_busy  <= (state_nxt != S_IDLE);
      case (state)
        S_IDLE: begin
          if (any_req) begin
            gnt           <= sel;
            last_grant    <= sel;
            req0_ack      <= ~sel;
            req1_ack      <= sel;
            spi_wr        <= sel ? req1_wr : req0_wr;
            spi_cs_length <= sel_len;
            spi_data_in   <= sel ? req1_data : req0_data;
            err_q         <= ~sel_len_ok;
          end
        end
        S_START: begin
          spi_start <= 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
          tmo_cnt   <= '0;
`endif
        end
        S_BUSY, S_WAIT_RD: begin
`ifdef SPI_ARB_TIMEOUT_EN
          tmo_cnt <= tmo_cnt + 8'd1;
`endif
          if (state == S_WAIT_RD && spi_data_valid) begin
            if (gnt) req1_rdata <= spi_data_out;
            else     req0_rdata <= spi_data_out;
          end
          if (abort) err_q <= 1'b1;
        end
        S_DONE: begin
          // Error completions clear the stale read data of the owning requester.
          if (gnt) begin
            req1_done <= 1'b1;
            req1_err  <= err_q;
            if (err_q) req1_rdata <= '0;
          end else begin
            req0_done <= 1'b1;
            req0_err  <= err_q;
            if (err_q) req0_rdata <= '0;
          end
          gap_cnt <= '0;
        end
        S_GAP:   gap_cnt <= gap_cnt + 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jft_spi_arb.sv
// Scoreboard bench for jft_spi_arb with a behavioural jft_spi engine model.
`timescale 1ns/1ps
module tb_jft_spi_arb;
  localparam int GAP = 2;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid, req0_wr, req1_valid, req1_wr;
  logic [6:0]  req0_len, req1_len;
  logic [39:0] req0_data, req1_data;
  logic        req0_ack, req0_done, req0_err, req1_ack, req1_done, req1_err;
  logic [31:0] req0_rdata, req1_rdata;
  logic        spi_start, spi_wr, spi_end, spi_data_valid, arb_busy;
  logic [6:0]  spi_start_number, spi_cs_length;
  logic [39:0] spi_data_in;
  logic [31:0] spi_data_out;

  always #5 clk = ~clk;

  jft_spi_arb #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .spi_clk_in(clk), .spi_rst_n_in(rst_n),
    .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_len(req0_len), .req0_data(req0_data),
    .req0_ack(req0_ack), .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_len(req1_len), .req1_data(req1_data),
    .req1_ack(req1_ack), .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_err(req1_err),
    .spi_start(spi_start), .spi_wr(spi_wr), .spi_start_number(spi_start_number),
    .spi_cs_length(spi_cs_length), .spi_data_in(spi_data_in),
    .spi_end(spi_end), .spi_data_valid(spi_data_valid), .spi_data_out(spi_data_out),
    .arb_busy(arb_busy)
  );

  typedef struct {
    int          id;
    logic        wr;
    logic [6:0]  len;
    logic [39:0] data;
    bit          legal;
    bit          err;
    bit          tmo;
    logic [31:0] rdata;
  } exp_t;

  exp_t        gnt_q[$];
  exp_t        done_q[$];
  exp_t        cur, mon_e;
  int          n_chk = 0, n_fail = 0, cyc = 0, n_done = 0;
  int          evt_cyc = 0, start_cyc = 0, ack_cyc = 0, last_done_cyc = 0;
  int          n_start = 0, n_start_exp = 0, eng_evts = 0, stray_req = 0, stray_done = 0;
  bit          have_done = 0, start_due = 0, chk_gap = 0, eng_mute = 0, eng_hold_rd = 0;
  logic        eng_wr, mon_err;
  logic [31:0] mon_rdata;
  logic [39:0] eng_d;
  logic [31:0] m_rdata [2];
  bit          m_last;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic tie_wr(input int id, input int k);
    return 1'((id + k) & 1);
  endfunction
  function automatic logic [6:0] tie_len(input int id, input int k);
    return 7'(8 + 8 * id + k);
  endfunction
  function automatic logic [39:0] tie_dat(input int id, input int k);
    return {8'(16 * id + k + 1), 32'hC0DE_0000 | 32'(16 * id + k)};
  endfunction

  // Expected completion model: write keeps old rdata, read returns frame bits [31:0].
  task automatic push_exp(input int id, input logic wr, input logic [6:0] len,
                          input logic [39:0] data, input bit tmo);
    exp_t e;
    e.id = id; e.wr = wr; e.len = len; e.data = data; e.tmo = tmo;
    e.legal = (len != 7'd0) && (len <= 7'd40);
    e.err = !e.legal || tmo;
    if (e.err)    e.rdata = '0;
    else if (wr)  e.rdata = data[31:0];
    else          e.rdata = m_rdata[id];
    m_rdata[id] = e.rdata;
    m_last = (id != 0);
    gnt_q.push_back(e);
  endtask

  task automatic set_req(input int id, input logic wr, input logic [6:0] len,
                         input logic [39:0] data, input logic vld);
    if (id == 0) begin
      req0_wr = wr; req0_len = len; req0_data = data; req0_valid = vld;
    end else begin
      req1_wr = wr; req1_len = len; req1_data = data; req1_valid = vld;
    end
  endtask

  task automatic drive_req(input int id, input logic wr, input logic [6:0] len,
                           input logic [39:0] data, input bit tmo);
    int c0;
    bit idle, got;
    @(posedge clk); #1;
    push_exp(id, wr, len, data, tmo);
    c0 = cyc;
    idle = !arb_busy;
    set_req(id, wr, len, data, 1'b1);
    got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if ((id == 0) ? req0_ack : req1_ack) got = 1;
    end
    check("ack_seen", 64'(got), 64'd1);
    if (got && idle) check("ack_latency", 64'(cyc - c0), 64'd1);
    @(posedge clk); #1;
    set_req(id, wr, len, data, 1'b0);
  endtask

  task automatic tie_thread(input int id, input int n);
    bit got;
    for (int k = 0; k < n; k++) begin
      set_req(id, tie_wr(id, k), tie_len(id, k), tie_dat(id, k), 1'b1);
      got = 0;
      for (int i = 0; i < 400 && !got; i++) begin
        @(negedge clk);
        if ((id == 0) ? req0_ack : req1_ack) got = 1;
      end
      check("tie_ack_seen", 64'(got), 64'd1);
    end
    set_req(id, 1'b0, 7'd0, 40'd0, 1'b0);
  endtask

  task automatic push_tie(input int n_tot);
    int g;
    int k0, k1;
    k0 = 0; k1 = 0;
    for (int n = 0; n < n_tot; n++) begin
      g = m_last ? 0 : 1;
      if (g == 0) begin push_exp(0, tie_wr(0, k0), tie_len(0, k0), tie_dat(0, k0), 0); k0++; end
      else        begin push_exp(1, tie_wr(1, k1), tie_len(1, k1), tie_dat(1, k1), 0); k1++; end
    end
  endtask

  task automatic wait_quiet();
    bit ok;
    ok = 0;
    for (int i = 0; i < 800 && !ok; i++) begin
      @(negedge clk);
      ok = (gnt_q.size() == 0) && (done_q.size() == 0) && !arb_busy;
    end
    check("quiet", 64'(ok), 64'd1);
  endtask

  task automatic chk_reset_vals();
    check("rst_busy", 64'(arb_busy), 64'd0);
    check("rst_ack0", 64'(req0_ack), 64'd0);
    check("rst_ack1", 64'(req1_ack), 64'd0);
    check("rst_done0", 64'(req0_done), 64'd0);
    check("rst_done1", 64'(req1_done), 64'd0);
    check("rst_err0", 64'(req0_err), 64'd0);
    check("rst_err1", 64'(req1_err), 64'd0);
    check("rst_rdata0", 64'(req0_rdata), 64'd0);
    check("rst_rdata1", 64'(req1_rdata), 64'd0);
    check("rst_start", 64'(spi_start), 64'd0);
    check("rst_wr", 64'(spi_wr), 64'd0);
    check("rst_cs_len", 64'(spi_cs_length), 64'd0);
    check("rst_data_in", 64'(spi_data_in), 64'd0);
    check("start_number", 64'(spi_start_number), 64'd1);
  endtask

  // Engine model: end 3 cycles after start; reads return frame bits [31:0] 2 cycles later.
  initial begin
    spi_end = 1'b0; spi_data_valid = 1'b0; spi_data_out = '0;
    forever begin
      @(negedge clk);
      if (spi_start && !eng_mute) begin
        eng_wr = spi_wr;
        eng_d  = spi_data_in;
        repeat (3) @(posedge clk);
        #1 spi_end = 1'b1; evt_cyc = cyc; eng_evts++;
        @(posedge clk);
        #1 spi_end = 1'b0;
        if (eng_wr && !eng_hold_rd) begin
          repeat (2) @(posedge clk);
          #1 spi_data_valid = 1'b1; spi_data_out = eng_d[31:0]; evt_cyc = cyc;
          @(posedge clk);
          #1 spi_data_valid = 1'b0; spi_data_out = 32'hDEAD_BEEF;
        end
      end else if (stray_req != stray_done) begin
        spi_end = 1'b1; spi_data_valid = 1'b1; spi_data_out = 32'hFFFF_FFFF;
        @(negedge clk);
        spi_end = 1'b0; spi_data_valid = 1'b0;
        stray_done++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      start_due = 0; have_done = 0;
      gnt_q.delete(); done_q.delete();
    end else begin
      if (spi_start) begin n_start++; start_cyc = cyc; end
      if (start_due && cyc == ack_cyc + 1) begin
        start_due = 0;
        check("start_after_ack", 64'(spi_start), 64'(cur.legal));
        if (cur.legal) begin
          check("spi_data_in", 64'(spi_data_in), 64'(cur.data));
          check("spi_cs_length", 64'(spi_cs_length), 64'(cur.len));
          check("spi_wr", 64'(spi_wr), 64'(cur.wr));
        end
      end
      if (req0_ack || req1_ack) begin
        check("single_ack", 64'(req0_ack & req1_ack), 64'd0);
        if (gnt_q.size() == 0) check("unexpected_ack", 64'd1, 64'd0);
        else begin
          cur = gnt_q.pop_front();
          check("grant_id", 64'(req1_ack), 64'(cur.id));
          if (chk_gap && have_done) check("gap", 64'(cyc - last_done_cyc), 64'(GAP + 1));
          ack_cyc = cyc; start_due = 1;
          if (cur.legal) n_start_exp++;
          done_q.push_back(cur);
        end
      end
      if (req0_done || req1_done) begin
        n_done++;
        check("single_done", 64'(req0_done & req1_done), 64'd0);
        mon_err   = req1_done ? req1_err : req0_err;
        mon_rdata = req1_done ? req1_rdata : req0_rdata;
        if (done_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
        else begin
          mon_e = done_q.pop_front();
          check("done_id", 64'(req1_done), 64'(mon_e.id));
          check("done_err", 64'(mon_err), 64'(mon_e.err));
          check("done_rdata", 64'(mon_rdata), 64'(mon_e.rdata));
          if (mon_e.tmo)
            check("tmo_latency", 64'((cyc - start_cyc >= TMO) && (cyc - start_cyc <= TMO + 2)), 64'd1);
          else if (mon_e.legal) check("done_latency", 64'(cyc - evt_cyc), 64'd2);
          else                  check("err_done_latency", 64'(cyc - ack_cyc), 64'd1);
        end
        last_done_cyc = cyc; have_done = 1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, n_chk %0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, d0;
    bit ok;
    set_req(0, 1'b0, 7'd0, 40'd0, 1'b0);
    set_req(1, 1'b0, 7'd0, 40'd0, 1'b0);
    m_rdata[0] = '0; m_rdata[1] = '0; m_last = 1;
    repeat (3) @(posedge clk);
    #1 chk_reset_vals();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Engine strobes while idle must be ignored.
    stray_req++;
    repeat (4) @(posedge clk); #1;
    check("stray_idle_busy", 64'(arb_busy), 64'd0);

    drive_req(0, 1'b0, 7'd24, 40'hAB_CDEF_0000, 0);
    wait_quiet();
    drive_req(1, 1'b1, 7'd32, 40'h00_1234_5678, 0);
    wait_quiet();
    drive_req(0, 1'b0, 7'd0, 40'h11_2233_4455, 0);
    wait_quiet();
    drive_req(0, 1'b1, 7'd41, 40'h66_7788_99AA, 0);
    wait_quiet();
    drive_req(0, 1'b0, 7'd40, 40'hFE_DCBA_9876, 0);
    wait_quiet();

    // Contention from reset: alternating grants with the full gap between them.
    @(posedge clk); #1 rst_n = 1'b0;
    m_rdata[0] = '0; m_rdata[1] = '0; m_last = 1;
    repeat (2) @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_gap = 1;
    push_tie(4);
    fork
      tie_thread(0, 2);
      tie_thread(1, 2);
    join
    wait_quiet();
    chk_gap = 0;

`ifdef SPI_ARB_TIMEOUT_EN
    eng_mute = 1;
    drive_req(1, 1'b1, 7'd20, 40'h0F_0F0F_0F0F, 1);
    wait_quiet();
    stray_req++;
    repeat (6) @(posedge clk); #1;
    check("late_end_busy", 64'(arb_busy), 64'd0);
    eng_mute = 0;
`endif

    // Reset while waiting for read data: no done, and last_grant returns to 1.
    eng_hold_rd = 1;
    e0 = eng_evts;
    drive_req(0, 1'b1, 7'd16, 40'h55_AAAA_5555, 0);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk);
      ok = (eng_evts != e0);
    end
    check("abort_end_seen", 64'(ok), 64'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1 chk_reset_vals();
    m_rdata[0] = '0; m_rdata[1] = '0; m_last = 1;
    d0 = n_done;
    eng_hold_rd = 0;
    repeat (3) @(posedge clk); #1 rst_n = 1'b1;
    repeat (6) @(posedge clk); #1;
    check("no_done_after_abort", 64'(n_done - d0), 64'd0);
    push_tie(2);
    fork
      tie_thread(0, 1);
      tie_thread(1, 1);
    join
    wait_quiet();

    check("start_count", 64'(n_start), 64'(n_start_exp));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
